// File: rtl/cpack_word_decoder_if.sv
// Token-in / word-out bundle for the compressed-word decoder.
// Carries the upstream token handshake, the flush request and the downstream word handshake.
// The master side drives tokens and downstream ready; the slave (decoder) drives ready, word, error and count.
interface cpack_word_decoder_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int IW = $clog2(DEPTH);

    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_codes;
    logic [1:0]       i_codes_bak;
    logic [WIDTH-1:0] i_literal;
    logic [IW-1:0]    i_idx;
    logic             o_valid;
    logic             i_ds_ready;
    logic [WIDTH-1:0] o_word;
    logic             o_err;
    logic [IW:0]      o_dict_cnt;

    modport master (
        output i_flush, i_valid, i_codes, i_codes_bak, i_literal, i_idx, i_ds_ready,
        input  o_ready, o_valid, o_word, o_err, o_dict_cnt
    );

    modport slave (
        input  i_flush, i_valid, i_codes, i_codes_bak, i_literal, i_idx, i_ds_ready,
        output o_ready, o_valid, o_word, o_err, o_dict_cnt
    );
endinterface

// File: rtl/cpack_word_decoder.sv
// Decodes C-Pack style tokens into full words using a small FIFO-replaced dictionary.
// Latency: 1 cycle from token accept to registered word; full throughput when downstream is ready.
// Backpressure: ready drops while the held word is stalled or during flush; held word stays stable.
module cpack_word_decoder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input logic               i_clk,
    input logic               i_rst_n,
    cpack_word_decoder_if.slave bus
);
    localparam int          IW       = $clog2(DEPTH);
    localparam logic [IW:0] CNT_FULL = (IW+1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_ZZZZ, OP_XXXX, OP_MMMM, OP_MMXX, OP_ZZZX, OP_MMMX, OP_RSVD
    } op_t;

    logic [WIDTH-1:0] dict [DEPTH];
    logic [IW-1:0]    wp;
    logic [IW:0]      dict_cnt;

    logic             vld_q;
    logic [WIDTH-1:0] word_q;
    logic             err_q;

    logic             accept;
    op_t              op;
    logic [WIDTH-1:0] dict_rd;
    logic             idx_ok;
    logic [WIDTH-1:0] dec_word;
    logic             dec_err;
    logic             dec_push;

    // Ready never looks at valid; a flush cycle blocks acceptance so the dictionary clear wins.
    assign bus.o_ready = ~bus.i_flush & (~vld_q | bus.i_ds_ready);
    assign accept      = bus.i_valid & bus.o_ready;

    // Dictionary is read from registered state only, so last cycle's push is already visible.
    assign dict_rd = dict[bus.i_idx];
    assign idx_ok  = ({1'b0, bus.i_idx} < dict_cnt);

    // Fold the primary and extended code fields into one operation.
    always_comb begin
        op = OP_ZZZZ;
        case (bus.i_codes)
            2'b00: op = OP_ZZZZ;
            2'b01: op = OP_XXXX;
            2'b10: op = OP_MMMM;
            default: begin
                case (bus.i_codes_bak)
                    2'b00:   op = OP_MMXX;
                    2'b01:   op = OP_ZZZX;
                    2'b10:   op = OP_MMMX;
                    default: op = OP_RSVD;
                endcase
            end
        endcase
    end

    // Build the decoded word, error flag and whether it enters the dictionary.
    always_comb begin
        dec_word = '0;
        dec_err  = 1'b0;
        dec_push = 1'b0;
        case (op)
            OP_ZZZZ: dec_word = '0;
            OP_XXXX: begin
                dec_word = bus.i_literal;
                dec_push = 1'b1;
            end
            OP_MMMM: begin
                dec_word = dict_rd;
                dec_err  = ~idx_ok;
            end
            OP_MMXX: begin
                dec_word = {dict_rd[WIDTH-1:WIDTH/2], bus.i_literal[WIDTH/2-1:0]};
                dec_err  = ~idx_ok;
                dec_push = 1'b1;
            end
            OP_ZZZX: dec_word = {{(WIDTH-8){1'b0}}, bus.i_literal[7:0]};
            OP_MMMX: begin
                dec_word = {dict_rd[WIDTH-1:8], bus.i_literal[7:0]};
                dec_err  = ~idx_ok;
                dec_push = 1'b1;
            end
            default: begin
                dec_word = '0;
                dec_err  = 1'b1;
            end
        endcase
    end

    // Output register: load on accept, drain when downstream takes the word, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q  <= 1'b0;
            word_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            vld_q  <= 1'b1;
            word_q <= dec_word;
            err_q  <= dec_err;
        end else if (bus.i_ds_ready) begin
            vld_q  <= 1'b0;
        end
    end

    // Dictionary: flush clears everything, pushes overwrite the oldest slot round-robin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) dict[i] <= '0;
            wp       <= '0;
            dict_cnt <= '0;
        end else if (bus.i_flush) begin
            for (int i = 0; i < DEPTH; i++) dict[i] <= '0;
            wp       <= '0;
            dict_cnt <= '0;
        end else if (accept && dec_push) begin
            dict[wp] <= dec_word;
            wp       <= wp + 1'b1;
            if (dict_cnt != CNT_FULL) dict_cnt <= dict_cnt + 1'b1;
        end
    end

    assign bus.o_valid    = vld_q;
    assign bus.o_word     = word_q;
    assign bus.o_err      = err_q;
    assign bus.o_dict_cnt = dict_cnt;
endmodule

// File: tb/tb_cpack_word_decoder.sv
// Self-checking bench for cpack_word_decoder: directed scenarios plus random tokens.
// Reference keeps the push history since last flush/reset; entry k is the latest push at position k mod DEPTH.
// Outputs are sampled 1 time unit after the rising edge, ready is sampled on the falling edge.
module tb_cpack_word_decoder;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpack_word_decoder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    cpack_word_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [31:0] hist[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_word  = '0;
    logic        m_err   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int mcount();
        return (hist.size() < DEPTH) ? hist.size() : DEPTH;
    endfunction

    function automatic logic [31:0] mentry(input int k);
        int n;
        int j;
        n = hist.size();
        if (n <= k) return 32'h0;
        j = (n - 1) - ((n - 1 - k) % DEPTH);
        return hist[j];
    endfunction

    task automatic mdecode(input logic [1:0] c, input logic [1:0] b, input logic [31:0] lit,
                           input int idx, output logic [31:0] w, output logic e, output logic p);
        logic [31:0] d;
        logic        miss;
        d    = mentry(idx);
        miss = (idx >= mcount());
        w = 32'h0; e = 1'b0; p = 1'b0;
        if (c == 2'd0) begin
            w = 32'h0;
        end else if (c == 2'd1) begin
            w = lit; p = 1'b1;
        end else if (c == 2'd2) begin
            w = d; e = miss;
        end else begin
            case (b)
                2'd0: begin w = (d & 32'hFFFF_0000) | (lit & 32'h0000_FFFF); e = miss; p = 1'b1; end
                2'd1: begin w = lit & 32'h0000_00FF; end
                2'd2: begin w = (d & 32'hFFFF_FF00) | (lit & 32'h0000_00FF); e = miss; p = 1'b1; end
                default: begin w = 32'h0; e = 1'b1; end
            endcase
        end
    endtask

    // One clock: check ready on the falling edge, advance the model, check outputs after the edge.
    task automatic step();
        logic        exp_rdy;
        logic        acc;
        logic        fl;
        logic        ds;
        logic [31:0] w;
        logic        e;
        logic        p;
        @(negedge clk);
        fl      = bus.i_flush;
        ds      = bus.i_ds_ready;
        exp_rdy = !fl && (!m_valid || ds);
        chk("o_ready", 64'(bus.o_ready), 64'(exp_rdy));
        acc = bus.i_valid && exp_rdy;
        w = 32'h0; e = 1'b0; p = 1'b0;
        if (acc) mdecode(bus.i_codes, bus.i_codes_bak, bus.i_literal, int'(bus.i_idx), w, e, p);
        @(posedge clk);
        #1;
        if (fl) hist.delete();
        else if (acc && p) hist.push_back(w);
        if (acc) begin
            m_valid = 1'b1; m_word = w; m_err = e;
        end else if (ds) begin
            m_valid = 1'b0;
        end
        chk("o_valid", 64'(bus.o_valid), 64'(m_valid));
        chk("o_word", 64'(bus.o_word), 64'(m_word));
        chk("o_err", 64'(bus.o_err), 64'(m_err));
        chk("o_dict_cnt", 64'(bus.o_dict_cnt), 64'(mcount()));
    endtask

    task automatic tok(input logic fl, input logic v, input logic [1:0] c, input logic [1:0] b,
                       input logic [31:0] lit, input int idx, input logic ds);
        bus.i_flush     = fl;
        bus.i_valid     = v;
        bus.i_codes     = c;
        bus.i_codes_bak = b;
        bus.i_literal   = lit;
        bus.i_idx       = 4'(idx);
        bus.i_ds_ready  = ds;
        step();
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_word", 64'(bus.o_word), 64'(0));
        chk("rst_err", 64'(bus.o_err), 64'(0));
        chk("rst_cnt", 64'(bus.o_dict_cnt), 64'(0));
        chk("rst_ready", 64'(bus.o_ready), 64'(1));
        hist.delete();
        m_valid = 1'b0; m_word = '0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("rst_ready_hold", 64'(bus.o_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_codes = 2'd0; bus.i_codes_bak = 2'd0;
        bus.i_literal = '0; bus.i_idx = '0; bus.i_ds_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // literal then full match
        tok(0, 1, 2'd1, 2'd0, 32'hDEADBEEF, 0, 1);
        chk("r33_word", 64'(bus.o_word), 64'h0DEADBEEF);
        chk("r33_cnt", 64'(bus.o_dict_cnt), 64'd1);
        tok(0, 1, 2'd2, 2'd3, 32'h0, 0, 1);
        chk("r33_match", 64'(bus.o_word), 64'h0DEADBEEF);
        chk("r33_err", 64'(bus.o_err), 64'd0);

        // partial matches and zero-extended byte
        tok(0, 1, 2'd3, 2'd0, 32'h0000_1234, 0, 1);
        chk("r34_mmxx", 64'(bus.o_word), 64'h0DEAD1234);
        tok(0, 1, 2'd3, 2'd2, 32'hFFFF_FF56, 1, 1);
        chk("r34_mmmx", 64'(bus.o_word), 64'h0DEAD1256);
        chk("r34_cnt3", 64'(bus.o_dict_cnt), 64'd3);
        tok(0, 1, 2'd3, 2'd1, 32'h1234_56AB, 7, 1);
        chk("r34_zzzx", 64'(bus.o_word), 64'h0000000AB);
        chk("r34_cnt_keep", 64'(bus.o_dict_cnt), 64'd3);

        // wrap: 17 pushes, oldest slot replaced
        tok(1, 0, 2'd0, 2'd0, 32'h0, 0, 1);
        for (int i = 0; i <= 16; i++) tok(0, 1, 2'd1, 2'd0, 32'(i), 0, 1);
        chk("r35_cnt", 64'(bus.o_dict_cnt), 64'd16);
        tok(0, 1, 2'd2, 2'd0, 32'h0, 0, 1);
        chk("r35_idx0", 64'(bus.o_word), 64'd16);
        tok(0, 1, 2'd2, 2'd0, 32'h0, 1, 1);
        chk("r35_idx1", 64'(bus.o_word), 64'd1);

        // empty dictionary and reserved code
        tok(1, 0, 2'd0, 2'd0, 32'h0, 0, 1);
        tok(0, 1, 2'd2, 2'd0, 32'h0, 5, 1);
        chk("r36_miss_word", 64'(bus.o_word), 64'd0);
        chk("r36_miss_err", 64'(bus.o_err), 64'd1);
        tok(0, 1, 2'd3, 2'd3, 32'hFFFF_FFFF, 0, 1);
        chk("r36_rsvd_word", 64'(bus.o_word), 64'd0);
        chk("r36_rsvd_err", 64'(bus.o_err), 64'd1);
        chk("r36_rsvd_cnt", 64'(bus.o_dict_cnt), 64'd0);

        // downstream stall for 3 cycles then resume at full rate
        tok(0, 1, 2'd1, 2'd0, 32'hCAFE0001, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tok(0, 1, 2'd1, 2'd0, 32'hCAFE0002, 0, 0);
            chk("r37_hold", 64'(bus.o_word), 64'h0CAFE0001);
        end
        for (int i = 2; i <= 5; i++) begin
            tok(0, 1, 2'd1, 2'd0, 32'hCAFE0000 + 32'(i), 0, 1);
            chk("r37_resume", 64'(bus.o_word), 64'h0CAFE0000 + 64'(i));
        end

        // flush blocks the token; re-presented token lands in a clean dictionary
        tok(1, 1, 2'd1, 2'd0, 32'h0000_0077, 0, 1);
        chk("r38_flush_cnt", 64'(bus.o_dict_cnt), 64'd0);
        tok(0, 1, 2'd1, 2'd0, 32'h0000_0077, 0, 1);
        tok(0, 1, 2'd2, 2'd0, 32'h0, 0, 1);
        chk("r38_match", 64'(bus.o_word), 64'h77);
        chk("r38_err", 64'(bus.o_err), 64'd0);

        // reset mid-stream with a populated dictionary
        for (int i = 0; i < 5; i++) tok(0, 1, 2'd1, 2'd0, 32'h5A00 + 32'(i), 0, 0);
        do_reset();
        tok(0, 1, 2'd2, 2'd0, 32'h0, 0, 1);
        chk("r31_after_rst_word", 64'(bus.o_word), 64'd0);
        chk("r31_after_rst_err", 64'(bus.o_err), 64'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] lit;
            lit = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            if (i == 1500) do_reset();
            tok(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), lit,
                $urandom_range(0, DEPTH - 1), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
